// File: rtl/axis_eth_fcs_insert.sv
// axis_eth_fcs_insert: AXI4-Stream Ethernet FCS inserter with optional zero padding to the minimum frame length.
module axis_eth_fcs_insert #(
    parameter int DATA_WIDTH       = 8,
    parameter int KEEP_ENABLE      = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy
);
    localparam int CW = $clog2(MIN_FRAME_LENGTH + 1);
    typedef enum logic [1:0] {PAYLOAD, PAD, FCS} state_t;
    state_t st, st_n;
    logic [31:0] crc, crc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] fk, fk_n;
    logic tuser_q, tuser_q_n, busy_n;
    logic [DATA_WIDTH-1:0] tdata_n;
    logic [KEEP_WIDTH-1:0] tkeep_n, keep;
    logic tvalid_n, tlast_n, tuser_n, ld, acc, gen, tail;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int j = 0; j < 8; j++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign ld = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && st == PAYLOAD && ld;
    assign acc = s_axis_tvalid && s_axis_tready;
    assign gen = st == PAYLOAD ? acc : ld;
    assign tail = st != PAYLOAD || s_axis_tlast;
    assign keep = KEEP_ENABLE != 0 ? s_axis_tkeep : '1;

    // Each lane is filled in order: payload, then pad zeros, then FCS bytes LSB first.
    always_comb begin
        st_n = st;
        crc_n = crc;
        cnt_n = cnt;
        fk_n = fk;
        tuser_q_n = tuser_q;
        tdata_n = m_axis_tdata;
        tkeep_n = m_axis_tkeep;
        tvalid_n = m_axis_tvalid && !m_axis_tready;
        tlast_n = m_axis_tlast;
        tuser_n = m_axis_tuser;
        busy_n = acc ? 1'b1 : (m_axis_tvalid && m_axis_tready && m_axis_tlast) ? 1'b0 : busy;
        if (gen) begin
            tvalid_n = 1'b1;
            tdata_n = '0;
            tkeep_n = '0;
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (st == PAYLOAD && keep[i]) begin
                    tdata_n[8*i +: 8] = s_axis_tdata[8*i +: 8];
                    tkeep_n[i] = 1'b1;
                    crc_n = crc_byte(crc_n, s_axis_tdata[8*i +: 8]);
                    cnt_n = cnt_n == CW'(MIN_FRAME_LENGTH) ? cnt_n : cnt_n + CW'(1);
                end else if (tail && ENABLE_PADDING != 0 && cnt_n < CW'(MIN_FRAME_LENGTH - 4)) begin
                    tkeep_n[i] = 1'b1;
                    crc_n = crc_byte(crc_n, 8'h00);
                    cnt_n = cnt_n + CW'(1);
                end else if (tail && fk_n != 3'd4) begin
                    tkeep_n[i] = 1'b1;
                    tdata_n[8*i +: 8] = 8'(~crc_n >> {fk_n, 3'b000});
                    fk_n = fk_n + 3'd1;
                end
            end
            tlast_n = fk_n == 3'd4;
            tuser_n = tlast_n && (st == PAYLOAD ? s_axis_tuser : tuser_q);
            if (st == PAYLOAD && s_axis_tlast) tuser_q_n = s_axis_tuser;
            if (tail) st_n = (ENABLE_PADDING != 0 && cnt_n < CW'(MIN_FRAME_LENGTH - 4)) ? PAD :
                             fk_n != 3'd4 ? FCS : PAYLOAD;
            if (tlast_n) begin
                crc_n = '1;
                cnt_n = '0;
                fk_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= PAYLOAD;
            crc <= '1;
            cnt <= '0;
            fk <= '0;
            tuser_q <= 1'b0;
            busy <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else begin
            st <= st_n;
            crc <= crc_n;
            cnt <= cnt_n;
            fk <= fk_n;
            tuser_q <= tuser_q_n;
            busy <= busy_n;
            m_axis_tdata <= tdata_n;
            m_axis_tkeep <= tkeep_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast <= tlast_n;
            m_axis_tuser <= tuser_n;
        end
    end
endmodule
